uart_cmd_fifo: RTL and testbench

Command queue sitting directly upstream of the `uart` block: it buffers 16-bit commands from a host-side producer and presents them one at a time on the `uart` command handshake (`cmd_in`/`cmd_vld`/`cmd_rdy`). The UART can take many cycles per command, so the host can post a burst of commands without stalling. Ordering is strict FIFO, with first-word-fall-through on the output.

---
 rtl/uart_cmd_fifo.sv | 97 +++++++++
 tb/tb_uart_cmd_fifo.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_fifo.sv
// uart_cmd_fifo: first-word-fall-through command queue feeding the uart
// command handshake (cmd_out/cmd_out_vld/cmd_out_rdy).
// Optional overflow statistics (ovf, drop_cnt) are built only when
// UART_CMD_FIFO_OVF_STAT_EN is defined; otherwise both outputs read as zero.
module uart_cmd_fifo #(
  parameter  int DW    = 16,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] s_data,
  input  logic          s_vld,
  output logic          s_rdy,
  output logic [DW-1:0] cmd_out,
  output logic          cmd_out_vld,
  input  logic          cmd_out_rdy,
  input  logic          clr,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty,
  output logic          ovf,
  output logic [7:0]    drop_cnt
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wp;
  logic [AW:0]   r_rp;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign w_full  = (r_wp[AW-1:0] == r_rp[AW-1:0]) && (r_wp[AW] != r_rp[AW]);
  assign w_empty = (r_wp == r_rp);

  // clr takes priority over any transfer in the same cycle.
  assign w_push = s_vld && !w_full && !clr;
  assign w_pop  = !w_empty && cmd_out_rdy && !clr;

  assign full        = w_full;
  assign empty       = w_empty;
  assign s_rdy       = !w_full;
  assign cmd_out_vld = !w_empty;
  assign cmd_out     = r_mem[r_rp[AW-1:0]];
  assign level       = r_wp - r_rp;

  // Storage array: written on accepted push, never reset or cleared.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wp[AW-1:0]] <= s_data;
    end
  end

  // Write and read pointers; wrap naturally at 2^(AW+1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp <= '0;
      r_rp <= '0;
    end else if (clr) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
    end
  end

`ifdef UART_CMD_FIFO_OVF_STAT_EN
  logic       r_ovf;
  logic [7:0] r_drop_cnt;
  logic       w_drop;

  assign w_drop   = s_vld && w_full && !clr;
  assign ovf      = r_ovf;
  assign drop_cnt = r_drop_cnt;

  // Sticky overflow flag and saturating dropped-push counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf      <= 1'b0;
      r_drop_cnt <= '0;
    end else if (clr) begin
      r_ovf      <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
      if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end
`else
  assign ovf      = 1'b0;
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_uart_cmd_fifo.sv
// Testbench for uart_cmd_fifo: queue-based reference model checked every
// cycle, plus directed checks for reset, fill, wrap, overflow and clr.
module tb_uart_cmd_fifo;

  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
`ifdef UART_CMD_FIFO_OVF_STAT_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] s_data;
  logic          s_vld;
  logic          s_rdy;
  logic [DW-1:0] cmd_out;
  logic          cmd_out_vld;
  logic          cmd_out_rdy;
  logic          clr;
  logic [AW:0]   level;
  logic          full;
  logic          empty;
  logic          ovf;
  logic [7:0]    drop_cnt;

  always #5 clk = ~clk;

  uart_cmd_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_data      (s_data),
    .s_vld       (s_vld),
    .s_rdy       (s_rdy),
    .cmd_out     (cmd_out),
    .cmd_out_vld (cmd_out_vld),
    .cmd_out_rdy (cmd_out_rdy),
    .clr         (clr),
    .level       (level),
    .full        (full),
    .empty       (empty),
    .ovf         (ovf),
    .drop_cnt    (drop_cnt)
  );

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: expected entries queued as pushes are driven, popped as
  // the consumer takes them.
  logic [DW-1:0] m_q[$];
  bit            m_ovf;
  int unsigned   m_drop;
  bit            chk_en = 1'b0;
  int unsigned   m_sz;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_ovf  = 1'b0;
      m_drop = 0;
    end else if (clr) begin
      m_q.delete();
      m_ovf  = 1'b0;
      m_drop = 0;
    end else begin
      m_sz = m_q.size();
      if (s_vld && m_sz == DEPTH && OVF_EN) begin
        m_ovf = 1'b1;
        if (m_drop < 255) m_drop = m_drop + 1;
      end
      if (cmd_out_rdy && m_sz > 0) void'(m_q.pop_front());
      if (s_vld && m_sz < DEPTH) m_q.push_back(s_data);
    end
  end

  task automatic model_check();
    check("m_vld",   cmd_out_vld, m_q.size() != 0);
    check("m_level", level,       m_q.size());
    check("m_full",  full,        m_q.size() == DEPTH);
    check("m_empty", empty,       m_q.size() == 0);
    check("m_rdy",   s_rdy,       m_q.size() != DEPTH);
    check("m_ovf",   ovf,         m_ovf);
    check("m_drop",  drop_cnt,    m_drop);
    if (m_q.size() != 0) check("m_data", cmd_out, m_q[0]);
  endtask

  always @(posedge clk) begin
    #2;
    if (chk_en) model_check();
  end

  task automatic push_n(input int unsigned n, input logic [DW-1:0] base);
    for (int unsigned i = 0; i < n; i++) begin
      s_vld  = 1'b1;
      s_data = base + DW'(i);
      @(negedge clk);
    end
    s_vld = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; s_vld = 1'b0; s_data = '0; cmd_out_rdy = 1'b0; clr = 1'b0;
    #12;
    check("rst_rdy",   s_rdy,       1);
    check("rst_vld",   cmd_out_vld, 0);
    check("rst_empty", empty,       1);
    check("rst_full",  full,        0);
    check("rst_level", level,       0);
    check("rst_ovf",   ovf,         0);
    check("rst_drop",  drop_cnt,    0);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Single command, consumer always ready.
    cmd_out_rdy = 1'b1;
    s_vld = 1'b1; s_data = 16'h000A;
    @(negedge clk);
    s_vld = 1'b0;
    check("single_vld",  cmd_out_vld, 1);
    check("single_data", cmd_out,     16'h000A);
    @(negedge clk);
    check("single_empty", empty, 1);

    // Fill under back-pressure, then drain in order.
    cmd_out_rdy = 1'b0;
    push_n(8, 16'h0001);
    check("fill_full",  full,    1);
    check("fill_level", level,   8);
    check("fill_rdy",   s_rdy,   0);
    check("fill_head",  cmd_out, 16'h0001);
    repeat (3) @(negedge clk);
    check("hold_head", cmd_out, 16'h0001);
    cmd_out_rdy = 1'b1;
    for (int unsigned i = 1; i <= 8; i++) begin
      check("drain_data", cmd_out, i);
      @(negedge clk);
    end
    check("drain_empty", empty, 1);

    // Steady push+pop at level 3 across pointer wrap.
    cmd_out_rdy = 1'b0;
    push_n(3, 16'h0100);
    cmd_out_rdy = 1'b1;
    for (int unsigned i = 0; i < 20; i++) begin
      s_vld  = 1'b1;
      s_data = 16'h0103 + DW'(i);
      check("pp_head", cmd_out, 16'h0100 + i);
      @(negedge clk);
      check("pp_level", level, 3);
    end
    s_vld = 1'b0;
    repeat (3) @(negedge clk);
    check("pp_empty", empty, 1);

    // Overflow: hold pushes against a full FIFO.
    cmd_out_rdy = 1'b0;
    push_n(8, 16'h0200);
    s_vld = 1'b1; s_data = 16'hDEAD;
    repeat (300) @(negedge clk);
    s_vld = 1'b0;
    check("ovf_flag",  ovf,      OVF_EN ? 1 : 0);
    check("ovf_drop",  drop_cnt, OVF_EN ? 255 : 0);
    check("ovf_level", level,    8);
    check("ovf_head",  cmd_out,  16'h0200);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_ovf",   ovf,      0);
    check("clr_drop",  drop_cnt, 0);
    check("clr_empty", empty,    1);

    // clr together with a push discards the push.
    push_n(5, 16'h0300);
    check("cp_level5", level, 5);
    clr = 1'b1; s_vld = 1'b1; s_data = 16'hBEEF;
    @(negedge clk);
    clr = 1'b0; s_vld = 1'b0;
    check("cp_level", level,       0);
    check("cp_vld",   cmd_out_vld, 0);
    @(negedge clk);
    check("cp_empty", empty, 1);

    // Asynchronous reset mid-operation.
    push_n(4, 16'h0400);
    #2 rst_n = 1'b0;
    #1;
    check("arst_vld",   cmd_out_vld, 0);
    check("arst_level", level,       0);
    check("arst_rdy",   s_rdy,       1);
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic: a filling phase then a draining phase.
    for (int unsigned i = 0; i < 400; i++) begin
      s_vld       = ($urandom_range(0, 3) != 0);
      s_data      = DW'($urandom);
      cmd_out_rdy = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      clr         = ($urandom_range(0, 59) == 0);
      @(negedge clk);
    end
    s_vld = 1'b0; clr = 1'b0; cmd_out_rdy = 1'b1;
    repeat (10) @(negedge clk);
    check("end_empty", empty, 1);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
